microc_call: RTL
================

Name: microc_call

Overview:
- Parametrised single-cycle microcontroller datapath, successor of the fixed 8-bit/10-bit core.
- Adds subroutine call/return through a hardware return-address stack, a carry flag, and a sticky stack-error flag.
- Program memory is external (instruction fetch port); the control unit is external and drives the same style of control strobes.
- Instruction word fixed at 16 bits.

Parameters:
- DATA_W, 8, register/ALU width; legal range 8..32.
- PC_W, 10, program counter width; legal range 4..10.
- STACK_DEPTH, 8, return-address stack entries; must be ≥2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state below
- instr  in  16  instruction fetched at address pc
- s_inc  in  1  1: sequential PC (pc+1); 0: jump to instr[PC_W-1:0]
- s_inm  in  1  1: write-back data is the immediate; 0: write-back data is the ALU result
- we3  in  1  register-file write enable
- wez  in  1  zero-flag write enable
- wec  in  1  carry-flag write enable
- push  in  1  call: push pc+1, load PC with target instr[PC_W-1:0]
- pop  in  1  return: load PC from top of stack
- Op  in  3  ALU operation
- pc  out  PC_W  current program counter (fetch address)
- Opcode  out  6  instr[15:10], combinational
- z  out  1  registered zero flag
- c  out  1  registered carry/borrow flag
- stk_err  out  1  sticky stack overflow/underflow/conflict flag
- sp  out  clog2(STACK_DEPTH+1)  stack occupancy, 0..STACK_DEPTH

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation): pc=0, sp=0, z=0, c=0, stk_err=0. Stack RAM and register file are not cleared.
- Fields:
  - ra1=instr[11:8], ra2=instr[7:4], wa=instr[3:0].
  - imm=instr[11:4], zero-extended to DATA_W.
  - Jump/call target = instr[PC_W-1:0].
- Register file: 16 x DATA_W.
  - Two asynchronous read ports; write on posedge clk when we3.
  - r0 always reads 0; writes to r0 are ignored.
  - Read of the address written in the same cycle returns the old value.
- ALU (combinational, A=RD1, B=RD2):
  - 000 A; 001 ~A; 010 A+B; 011 A-B; 100 A&B; 101 A|B; 110 -A; 111 -B.
  - Zero = (result==0).
  - Carry = carry-out for 010; borrow (A<B unsigned) for 011; 0 otherwise.
- Flags: z and c load on posedge only when wez/wec respectively; otherwise they hold.
- Next-PC priority, evaluated each cycle:
  1. push && pop: no stack change, stk_err<=1, pc<=pc+1.
  2. pop, sp==0 (underflow): stk_err<=1, pc<=pc+1.
  3. pop, sp>0: pc<=stack[sp-1], sp<=sp-1.
  4. push, sp==STACK_DEPTH (overflow): no write, sp holds, stk_err<=1, pc<=target.
  5. push, sp<STACK_DEPTH: stack[sp]<=pc+1, sp<=sp+1, pc<=target.
  6. s_inc=0: pc<=target.
  7. else: pc<=pc+1.
- Stack behaviour:
  - push/pop override s_inc.
  - Latency: a pushed address is poppable on the next cycle.
  - stk_err clears only on reset.
- PC arithmetic is modulo 2^PC_W; pc+1 from all-ones wraps to 0, including the pushed return address.
- Register write-back is independent of push/pop: a call instruction may also write a register if we3=1.

Decomposition:
- Package microc_pkg:
  - ALU op localparams (OP_PASS, OP_NOT, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NEGA, OP_NEGB).
  - Instruction field bit positions.
  - INSTR_W=16.
- Sub-module return_stack:
  - Parameters PC_W, STACK_DEPTH.
  - Ports push, pop, din, dout (top), sp, full, empty, err.
- The register file and ALU are inlined.

Test Plan:
- Reset mid-run: assert reset async at pc=0x05 with z=c=1 -> pc, sp, z, c, stk_err read 0 before the next clk edge.
- Immediate and add with carry: imm 0xF0->r1, imm 0x20->r2, Op=010 with wez/wec, wa=r3 -> r3=0x10, c=1, z=0 (DATA_W=8).
- Subtract with borrow: r1-r1 -> z=1, c=0. Then r2(0x20)-r1(0xF0) -> c=1, result 0x30.
- Nested call/return: push at pc=3 (target 0x40), push at 0x40 (target 0x80), pop, pop -> pc sequence 3, 0x40, 0x80, 0x41, 4; sp 0,1,2,1,0.
- Overflow (STACK_DEPTH=2): three pushes -> third still jumps, sp=2, stk_err=1. Two pops then return the first two return addresses.
- Underflow/conflict: pop with sp=0 -> pc+1, stk_err=1. After reset, push&&pop together -> sp=0, pc+1, stk_err=1. r0 write of 0xFF -> reads 0.

Source files
------------

// File: rtl/microc_pkg.sv
// Shared constants for the microc_call datapath: instruction field positions and ALU op codes.
package microc_pkg;
  localparam int INSTR_W = 16;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 10;
  localparam int RA1_HI = 11;
  localparam int RA1_LO = 8;
  localparam int RA2_HI = 7;
  localparam int RA2_LO = 4;
  localparam int WA_HI  = 3;
  localparam int WA_LO  = 0;
  localparam int IMM_HI = 11;
  localparam int IMM_LO = 4;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_NEGA = 3'b110;
  localparam logic [2:0] OP_NEGB = 3'b111;
endpackage

// File: rtl/microc_call_if.sv
// Control-strobe / fetch bundle between the external control unit (master) and the datapath (slave).
interface microc_call_if #(
  parameter int PC_W = 10,
  parameter int SP_W = 4
);
  logic [15:0]     instr;
  logic            s_inc;
  logic            s_inm;
  logic            we3;
  logic            wez;
  logic            wec;
  logic            push;
  logic            pop;
  logic [2:0]      Op;
  logic [PC_W-1:0] pc;
  logic [5:0]      Opcode;
  logic            z;
  logic            c;
  logic            stk_err;
  logic [SP_W-1:0] sp;

  modport master (
    output instr, s_inc, s_inm, we3, wez, wec, push, pop, Op,
    input  pc, Opcode, z, c, stk_err, sp
  );

  modport slave (
    input  instr, s_inc, s_inm, we3, wez, wec, push, pop, Op,
    output pc, Opcode, z, c, stk_err, sp
  );
endinterface

// File: rtl/microc_call_return_stack.sv
// Hardware return-address stack with occupancy count and a sticky overflow/underflow/conflict flag.
module return_stack #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 8,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1),
  localparam int IDX_W      = $clog2(STACK_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] dout,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty,
  output logic            err
);
  logic [PC_W-1:0]  mem_q [STACK_DEPTH];
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             err_q, err_d;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign full   = (sp_q == SP_W'(STACK_DEPTH));
  assign empty  = (sp_q == '0);
  assign wr_idx = IDX_W'(sp_q);
  assign rd_idx = IDX_W'(sp_q - SP_W'(1));
  // Guard the empty case so the read index never points past the array.
  assign dout   = empty ? '0 : mem_q[rd_idx];
  assign sp     = sp_q;
  assign err    = err_q;

  always_comb begin
    sp_d  = sp_q;
    err_d = err_q;
    wr_en = 1'b0;
    if (push && pop) begin
      err_d = 1'b1;
    end else if (pop) begin
      if (empty) err_d = 1'b1;
      else       sp_d  = sp_q - SP_W'(1);
    end else if (push) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        sp_d  = sp_q + SP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= din;
  end
endmodule

// File: rtl/microc_call.sv
// Single-cycle microcontroller datapath: register file, ALU, z/c flags and PC with call/return stack.
module microc_call
  import microc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 8,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input logic           clk,
  input logic           reset,
  microc_call_if.slave  bus
);
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc, target, stk_top;
  logic              z_q, z_d, c_q, c_d;
  logic [DATA_W-1:0] rf_q [16];
  logic [3:0]        ra1, ra2, wa;
  logic [7:0]        imm;
  logic [DATA_W-1:0] rd1, rd2, alu_y, wd;
  logic [DATA_W:0]   sum;
  logic              alu_c;
  logic              stk_empty, stk_err;
  logic [SP_W-1:0]   stk_sp;

  assign ra1 = bus.instr[RA1_HI:RA1_LO];
  assign ra2 = bus.instr[RA2_HI:RA2_LO];
  assign wa  = bus.instr[WA_HI:WA_LO];
  assign imm = bus.instr[IMM_HI:IMM_LO];

  assign rd1 = (ra1 == 4'd0) ? '0 : rf_q[ra1];
  assign rd2 = (ra2 == 4'd0) ? '0 : rf_q[ra2];

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    sum   = {1'b0, rd1} + {1'b0, rd2};
    case (bus.Op)
      OP_PASS: alu_y = rd1;
      OP_NOT:  alu_y = ~rd1;
      OP_ADD: begin
        alu_y = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
      end
      OP_SUB: begin
        alu_y = rd1 - rd2;
        alu_c = (rd1 < rd2);
      end
      OP_AND:  alu_y = rd1 & rd2;
      OP_OR:   alu_y = rd1 | rd2;
      OP_NEGA: alu_y = '0 - rd1;
      OP_NEGB: alu_y = '0 - rd2;
      default: alu_y = '0;
    endcase
  end

  assign wd = bus.s_inm ? DATA_W'(imm) : alu_y;

  // r0 is never written, so its storage is simply ignored on read.
  always_ff @(posedge clk) begin
    if (bus.we3 && (wa != 4'd0)) rf_q[wa] <= wd;
  end

  assign pc_inc = pc_q + 1'b1;
  assign target = bus.instr[PC_W-1:0];

  return_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (bus.push),
    .pop   (bus.pop),
    .din   (pc_inc),
    .dout  (stk_top),
    .sp    (stk_sp),
    .full  (),
    .empty (stk_empty),
    .err   (stk_err)
  );

  always_comb begin
    pc_d = pc_inc;
    if (bus.push && bus.pop)  pc_d = pc_inc;
    else if (bus.pop)         pc_d = stk_empty ? pc_inc : stk_top;
    else if (bus.push)        pc_d = target;
    else if (!bus.s_inc)      pc_d = target;
  end

  always_comb begin
    z_d = bus.wez ? (alu_y == '0) : z_q;
    c_d = bus.wec ? alu_c : c_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
      z_q  <= 1'b0;
      c_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      z_q  <= z_d;
      c_q  <= c_d;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.Opcode  = bus.instr[OPC_HI:OPC_LO];
  assign bus.z       = z_q;
  assign bus.c       = c_q;
  assign bus.stk_err = stk_err;
  assign bus.sp      = stk_sp;
endmodule
